// File: rtl/exc_commit_ctrl.sv
// WB-stage exception/ertn commit controller: selects one event per commit, drives the CSR
// exception interface and the pipeline flush/hold. Define EXC_COUNT_EN to add an exception counter.
module exc_commit_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [31:0]       wb_pc_in,
  input  logic [31:0]       wb_vaddr,
  input  logic              wb_adef,
  input  logic              wb_ale,
  input  logic              wb_sys,
  input  logic              wb_brk,
  input  logic              wb_ine,
  input  logic              wb_ertn,
  input  logic              csr_crmd_ie,
  input  logic [12:0]       csr_ecfg_lie,
  input  logic [12:0]       csr_estat_is,
  input  logic [31:0]       csr_eentry,
  input  logic [31:0]       csr_era,
  output logic              wb_ex,
  output logic [5:0]        wb_ecode,
  output logic [8:0]        wb_esubcode,
  output logic [31:0]       wb_pc,
  output logic              ertn_flush,
  output logic              badv_we,
  output logic [31:0]       badv_value,
  output logic              flush_valid,
  output logic [31:0]       flush_pc,
  output logic              pipe_hold
`ifdef EXC_COUNT_EN
  ,
  input  logic              exc_count_clr,
  output logic [CNT_W-1:0]  exc_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state;
  logic        int_pend_q;
  logic [3:0]  drain_cnt;

  logic        ev_take;
  logic        ev_ex;
  logic [5:0]  ev_ecode;
  logic        ev_badv_we;
  logic [31:0] ev_badv;

  // Fixed-priority event pick; any exception flag outranks ertn.
  always_comb begin
    ev_take    = 1'b1;
    ev_ex      = 1'b1;
    ev_ecode   = 6'h00;
    ev_badv_we = 1'b0;
    ev_badv    = 32'h0;
    if (int_pend_q) begin
      ev_ecode = 6'h00;
    end else if (wb_adef) begin
      ev_ecode   = 6'h08;
      ev_badv_we = 1'b1;
      ev_badv    = wb_pc_in;
    end else if (wb_ale) begin
      ev_ecode   = 6'h09;
      ev_badv_we = 1'b1;
      ev_badv    = wb_vaddr;
    end else if (wb_sys) begin
      ev_ecode = 6'h0B;
    end else if (wb_brk) begin
      ev_ecode = 6'h0C;
    end else if (wb_ine) begin
      ev_ecode = 6'h0D;
    end else if (wb_ertn) begin
      ev_ex = 1'b0;
    end else begin
      ev_take = 1'b0;
      ev_ex   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      int_pend_q  <= 1'b0;
      drain_cnt   <= 4'd0;
      wb_ready    <= 1'b1;
      wb_ex       <= 1'b0;
      wb_ecode    <= 6'h00;
      wb_esubcode <= 9'h000;
      wb_pc       <= 32'h0;
      ertn_flush  <= 1'b0;
      badv_we     <= 1'b0;
      badv_value  <= 32'h0;
      flush_valid <= 1'b0;
      flush_pc    <= 32'h0;
      pipe_hold   <= 1'b0;
    end else begin
      int_pend_q  <= csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
      // Event outputs are single-cycle pulses; they fall back to zero unless a commit is taken.
      wb_ex       <= 1'b0;
      wb_ecode    <= 6'h00;
      wb_esubcode <= 9'h000;
      wb_pc       <= 32'h0;
      ertn_flush  <= 1'b0;
      badv_we     <= 1'b0;
      badv_value  <= 32'h0;
      flush_valid <= 1'b0;
      flush_pc    <= 32'h0;
      case (state)
        IDLE: begin
          if (wb_valid && ev_take) begin
            state       <= FLUSH;
            wb_ready    <= 1'b0;
            pipe_hold   <= 1'b1;
            wb_ex       <= ev_ex;
            ertn_flush  <= ~ev_ex;
            wb_ecode    <= ev_ecode;
            wb_pc       <= wb_pc_in;
            badv_we     <= ev_badv_we;
            badv_value  <= ev_badv;
            flush_valid <= 1'b1;
            flush_pc    <= ev_ex ? csr_eentry : csr_era;
          end
        end
        FLUSH: begin
          state     <= DRAIN;
          drain_cnt <= DRAIN_LOAD;
        end
        DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state     <= IDLE;
            pipe_hold <= 1'b0;
            wb_ready  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          pipe_hold <= 1'b0;
          wb_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef EXC_COUNT_EN
  // Counts taken exceptions (ertn excluded); clear wins over a coincident pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_count <= '0;
    end else if (exc_count_clr) begin
      exc_count <= '0;
    end else if (wb_ex) begin
      exc_count <= exc_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed scenarios plus randomized commits
// compared every cycle against a hold-countdown reference model.
module tb_exc_commit_ctrl;

  localparam int DRAIN_CYCLES = 2;
  localparam int CNT_W        = 32;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc_in;
  logic [31:0] wb_vaddr;
  logic        wb_adef, wb_ale, wb_sys, wb_brk, wb_ine, wb_ertn;
  logic        csr_crmd_ie;
  logic [12:0] csr_ecfg_lie;
  logic [12:0] csr_estat_is;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic        badv_we;
  logic [31:0] badv_value;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        pipe_hold;
`ifdef EXC_COUNT_EN
  logic             exc_count_clr;
  logic [CNT_W-1:0] exc_count;
`endif

  exc_commit_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_pc_in(wb_pc_in), .wb_vaddr(wb_vaddr), .wb_adef(wb_adef), .wb_ale(wb_ale),
    .wb_sys(wb_sys), .wb_brk(wb_brk), .wb_ine(wb_ine), .wb_ertn(wb_ertn),
    .csr_crmd_ie(csr_crmd_ie), .csr_ecfg_lie(csr_ecfg_lie), .csr_estat_is(csr_estat_is),
    .csr_eentry(csr_eentry), .csr_era(csr_era), .wb_ex(wb_ex), .wb_ecode(wb_ecode),
    .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .ertn_flush(ertn_flush), .badv_we(badv_we),
    .badv_value(badv_value), .flush_valid(flush_valid), .flush_pc(flush_pc),
    .pipe_hold(pipe_hold)
`ifdef EXC_COUNT_EN
    , .exc_count_clr(exc_count_clr), .exc_count(exc_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic adef, input logic ale, input logic sys,
                               input logic brk, input logic ine, input logic ertn);
    wb_valid = v;
    wb_adef  = adef;
    wb_ale   = ale;
    wb_sys   = sys;
    wb_brk   = brk;
    wb_ine   = ine;
    wb_ertn  = ertn;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (wb_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("wait_idle_bound", 32'(n < 50), 32'd1);
  endtask

  // Reference model: an event opens a hold window of 1+DRAIN_CYCLES cycles whose first
  // cycle carries the pulses; commits are only seen while no window is open.
  typedef struct packed {
    logic        take;
    logic        ex;
    logic [5:0]  code;
    logic        bwe;
    logic [31:0] badv;
  } ev_t;

  function automatic ev_t pick(input logic ip, input logic adef, input logic ale, input logic sys,
                               input logic brk, input logic ine, input logic ertn,
                               input logic [31:0] pc, input logic [31:0] va);
    ev_t r;
    r = '0;
    r.take = 1'b1;
    r.ex   = 1'b1;
    if (ip)        r.code = 6'h00;
    else if (adef) begin r.code = 6'h08; r.bwe = 1'b1; r.badv = pc; end
    else if (ale)  begin r.code = 6'h09; r.bwe = 1'b1; r.badv = va; end
    else if (sys)  r.code = 6'h0B;
    else if (brk)  r.code = 6'h0C;
    else if (ine)  r.code = 6'h0D;
    else if (ertn) r.ex = 1'b0;
    else begin r.take = 1'b0; r.ex = 1'b0; end
    return r;
  endfunction

  int          m_hold = 0;
  logic        m_int = 1'b0, m_ex = 1'b0, m_ertn = 1'b0, m_bwe = 1'b0, m_fv = 1'b0;
  logic [5:0]  m_code = '0;
  logic [31:0] m_pc = '0, m_bv = '0, m_fpc = '0;
  logic [CNT_W-1:0] m_count = '0;

  always @(posedge clk or posedge reset) begin : model
    ev_t e;
    if (reset) begin
      m_hold <= 0; m_int <= 1'b0; m_ex <= 1'b0; m_ertn <= 1'b0; m_bwe <= 1'b0; m_fv <= 1'b0;
      m_code <= '0; m_pc <= '0; m_bv <= '0; m_fpc <= '0; m_count <= '0;
    end else begin
      e = pick(m_int, wb_adef, wb_ale, wb_sys, wb_brk, wb_ine, wb_ertn, wb_pc_in, wb_vaddr);
`ifdef EXC_COUNT_EN
      if (exc_count_clr) m_count <= '0;
      else if (m_ex)     m_count <= m_count + 1;
`endif
      m_ex <= 1'b0; m_ertn <= 1'b0; m_bwe <= 1'b0; m_fv <= 1'b0;
      m_code <= '0; m_pc <= '0; m_bv <= '0; m_fpc <= '0;
      if (m_hold != 0) begin
        m_hold <= m_hold - 1;
      end else if (wb_valid && e.take) begin
        m_hold <= 1 + DRAIN_CYCLES;
        m_ex   <= e.ex;
        m_ertn <= ~e.ex;
        m_code <= e.code;
        m_pc   <= wb_pc_in;
        m_bwe  <= e.bwe;
        m_bv   <= e.badv;
        m_fv   <= 1'b1;
        m_fpc  <= e.ex ? csr_eentry : csr_era;
      end
      m_int <= csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cmp_wb_ready",    wb_ready,    32'(m_hold == 0));
      checkOutput("cmp_pipe_hold",   pipe_hold,   32'(m_hold != 0));
      checkOutput("cmp_wb_ex",       wb_ex,       m_ex);
      checkOutput("cmp_ertn_flush",  ertn_flush,  m_ertn);
      checkOutput("cmp_wb_ecode",    wb_ecode,    m_code);
      checkOutput("cmp_wb_esubcode", wb_esubcode, 32'd0);
      checkOutput("cmp_wb_pc",       wb_pc,       m_pc);
      checkOutput("cmp_badv_we",     badv_we,     m_bwe);
      checkOutput("cmp_badv_value",  badv_value,  m_bv);
      checkOutput("cmp_flush_valid", flush_valid, m_fv);
      checkOutput("cmp_flush_pc",    flush_pc,    m_fpc);
`ifdef EXC_COUNT_EN
      checkOutput("cmp_exc_count",   exc_count,   m_count);
`endif
    end
  end

  initial begin : stim
    int n;
    int pulses;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    wb_pc_in = '0; wb_vaddr = '0; csr_crmd_ie = 1'b0; csr_ecfg_lie = '0; csr_estat_is = '0;
    csr_eentry = '0; csr_era = '0;
`ifdef EXC_COUNT_EN
    exc_count_clr = 1'b0;
`endif
    reset = 1'b0;
    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;
    checkOutput("reset_wb_ready", wb_ready, 32'd1);
    checkOutput("reset_pipe_hold", pipe_hold, 32'd0);
    checkOutput("reset_wb_ex", wb_ex, 32'd0);
    checkOutput("reset_flush_valid", flush_valid, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Syscall: pulse contents and hold window length
    wb_pc_in = 32'h1c000100; csr_eentry = 32'h1c008000;
    applyStimulus(1, 0, 0, 1, 0, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("sys_wb_ex", wb_ex, 32'd1);
    checkOutput("sys_ecode", wb_ecode, 32'h0B);
    checkOutput("sys_wb_pc", wb_pc, 32'h1c000100);
    checkOutput("sys_flush_pc", flush_pc, 32'h1c008000);
    n = 0;
    while (pipe_hold === 1'b1 && n < 20) begin
      checkOutput("sys_ready_low", wb_ready, 32'd0);
      n++;
      tick();
    end
    checkOutput("sys_hold_len", n, 32'(1 + DRAIN_CYCLES));
    checkOutput("sys_ready_after", wb_ready, 32'd1);

    // Address errors and their BADV values
    wb_vaddr = 32'h00000403;
    applyStimulus(1, 0, 1, 0, 0, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("ale_ecode", wb_ecode, 32'h09);
    checkOutput("ale_badv_we", badv_we, 32'd1);
    checkOutput("ale_badv_value", badv_value, 32'h00000403);
    waitIdle();
    wb_pc_in = 32'h1c000300;
    applyStimulus(1, 1, 1, 0, 0, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("adef_ecode", wb_ecode, 32'h08);
    checkOutput("adef_badv_value", badv_value, 32'h1c000300);
    waitIdle();

    // Interrupt beats break; masked interrupt does not
    csr_crmd_ie = 1'b1; csr_ecfg_lie = 13'h0800; csr_estat_is = 13'h0800;
    tick();
    applyStimulus(1, 0, 0, 0, 1, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("int_ecode", wb_ecode, 32'h00);
    checkOutput("int_wb_ex", wb_ex, 32'd1);
    waitIdle();
    csr_crmd_ie = 1'b0;
    tick();
    applyStimulus(1, 0, 0, 0, 1, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("brk_ecode", wb_ecode, 32'h0C);
    waitIdle();
    csr_ecfg_lie = '0; csr_estat_is = '0;

    // ertn alone and ertn combined with an exception
    csr_era = 32'h1c000200;
    applyStimulus(1, 0, 0, 0, 0, 0, 1); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("ertn_flush", ertn_flush, 32'd1);
    checkOutput("ertn_wb_ex", wb_ex, 32'd0);
    checkOutput("ertn_flush_pc", flush_pc, 32'h1c000200);
    waitIdle();
    applyStimulus(1, 0, 0, 0, 0, 1, 1); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("ine_wb_ex", wb_ex, 32'd1);
    checkOutput("ine_ecode", wb_ecode, 32'h0D);
    checkOutput("ine_ertn_flush", ertn_flush, 32'd0);
    waitIdle();

    // Commit with no event leaves the controller idle
    applyStimulus(1, 0, 0, 0, 0, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("noev_ready", wb_ready, 32'd1);
    checkOutput("noev_flush_valid", flush_valid, 32'd0);

    // wb_valid held through the hold window produces a single pulse
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 1 + DRAIN_CYCLES; i++) begin
      tick();
      pulses += int'(wb_ex);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("held_pulses", pulses, 32'd1);
    waitIdle();

    // Asynchronous reset in DRAIN
    applyStimulus(1, 0, 0, 1, 0, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_drain_hold", pipe_hold, 32'd0);
    checkOutput("rst_drain_ready", wb_ready, 32'd1);
    tick();
    reset = 1'b0;
    tick();

`ifdef EXC_COUNT_EN
    applyStimulus(1, 0, 0, 1, 0, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0); waitIdle();
    applyStimulus(1, 0, 0, 0, 1, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0); waitIdle();
    applyStimulus(1, 0, 1, 0, 0, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0); waitIdle();
    applyStimulus(1, 0, 0, 0, 0, 0, 1); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0); waitIdle();
    checkOutput("cnt_three", exc_count, 32'd3);
    applyStimulus(1, 0, 0, 1, 0, 0, 0); tick(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    exc_count_clr = 1'b1;
    tick();
    exc_count_clr = 1'b0;
    checkOutput("cnt_clr", exc_count, 32'd0);
    waitIdle();
`endif

    // Randomized commits, interrupts and CSR values
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 8) == 0, ($urandom % 6) == 0,
                    ($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
                    ($urandom % 5) == 0);
      wb_pc_in     = $urandom;
      wb_vaddr     = $urandom;
      csr_eentry   = $urandom;
      csr_era      = $urandom;
      csr_crmd_ie  = 1'($urandom % 2);
      csr_ecfg_lie = 13'($urandom);
      csr_estat_is = (($urandom % 8) == 0) ? 13'(1 << ($urandom % 13)) : 13'h0;
`ifdef EXC_COUNT_EN
      exc_count_clr = ($urandom % 16) == 0;
`endif
      if (i == 200) begin
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    csr_crmd_ie = 1'b0;
`ifdef EXC_COUNT_EN
    exc_count_clr = 1'b0;
`endif
    waitIdle();
    tick();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
